fnd_scan_controller: RTL and testbench
======================================

# fnd_scan_controller

Parametrised time-multiplexed seven-segment scanner, successor to the fixed 4-digit FND controller. It drives `NUM_DIGITS` common-anode digits from a packed BCD word with per-digit dot and blink enables, leading-zero blanking, anti-ghosting dead time, and a double-buffered load handshake. Updates reach the display only on frame boundaries, so a frame never mixes old and new data. It sits between the mode/data-select muxes (watch, SR04, DHT11) and the board FND pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned, legal range 1..8.
- `SCAN_DIV`, 100_000: clk cycles each digit is selected (1 kHz at 100 MHz). Must be ≥ `DEAD_CYCLES`+2.
- `DEAD_CYCLES`, 2: cycles at the start of each digit slot with all commons off.
- `BLINK_DIV`, 50_000_000: clk cycles per blink half-period.

- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `load`  in  1: single-cycle strobe that captures `digit_data`, `dot_en` and `blink_en`.
- `digit_data`  in  4*NUM_DIGITS: BCD nibbles. Nibble i drives digit i, digit 0 is rightmost.
- `dot_en`  in  NUM_DIGITS: per-digit decimal point on.
- `blink_en`  in  NUM_DIGITS: per-digit blink enable.
- `blank_lz`  in  1: leading-zero blanking enable. Level input, sampled live.
- `pending`  out  1: captured data is waiting for the next frame boundary.
- `frame_start`  out  1: one-cycle pulse when digit index wraps to 0.
- `fnd_com`  out  NUM_DIGITS: active-low one-hot digit select.
- `fnd_data`  out  8: active-low segments. Bit 7 is dp, bits 6:0 are g..a.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps. At terminal count the digit index `idx` advances and wraps NUM_DIGITS-1→0.
- A frame boundary is the cycle where `cnt`==SCAN_DIV-1 and `idx`==NUM_DIGITS-1.
  - On that edge: `idx`→0 and `frame_start`=1 for one cycle.
  - If `pending`=1, shadow registers take the pending registers and `pending` clears.
- `load`=1 copies the inputs into the pending registers and sets `pending`.
  - Repeated loads before a boundary overwrite the pending registers; the last one wins.
  - `load` on a boundary cycle: the shadow takes the old pending contents, the new load becomes pending, and `pending` stays 1.
- Blink: free-running counter 0..BLINK_DIV-1. `blink_on` toggles at terminal count.
- Digit content, computed from shadow registers:
  - Nibble 0–9 maps to c0,f9,a4,b0,99,92,82,f8,80,90 (bits 6:0 taken from these, bit 7 handled separately). Nibbles A–F give all segments off.
  - Leading-zero blanking: if `blank_lz`=1 and every nibble at index ≥ i is 0, and i≠0, segments 6:0 are off. Digit 0 always shows.
  - Blink: if `blink_en[i]`=1 and `blink_on`=0, all 8 bits are off, dp included.
  - dp (bit 7) = ~`dot_en[i]` unless blink-blanked.
- Dead time: while `cnt`<DEAD_CYCLES, `fnd_com`=all 1s and `fnd_data`=8'hff.

## Timing
- Reset values:
  - `fnd_com` all 1s, `fnd_data`=8'hff.
  - `pending`=0, `frame_start`=0.
  - `cnt`=0, `idx`=0, `blink_on`=1.
  - Shadow and pending registers all 0.
- `fnd_com` and `fnd_data` are registered and lag (`idx`, `cnt`, shadow) by exactly one clk.
- `load`→`pending`=1 on the next edge. Load to display takes at most one frame plus one cycle: NUM_DIGITS·SCAN_DIV+1.
- Digit slot length is exactly SCAN_DIV cycles: DEAD_CYCLES dark, then SCAN_DIV−DEAD_CYCLES lit.
- Reset mid-operation: all state returns to reset values immediately and asynchronously; pending data is discarded. After release, scanning restarts at digit 0 with `cnt`=0.
- `blank_lz` changes take effect on the next cycle, not at a frame boundary.

## Structure
- Shared package `fnd_pkg`:
  - segment constants `SEG_0`..`SEG_9`, `SEG_OFF`=8'hff;
  - BCD-to-segment function;
  - dead-time and blink default constants.
- One combinational sub-module `fnd_seg_decoder`: nibble, dot, blank, blink inputs → 8-bit segment pattern.
- Everything else stays in the top: prescaler, index counter, blink counter, pending/shadow registers, output registers.

## Test plan
- Reset: hold `reset`=0 → `fnd_com`=4'b1111, `fnd_data`=8'hff, `pending`=0. Release → first lit slot shows digit 0 = 8'hc0 (no blanking), `fnd_com`=4'b1110.
- Scan order (NUM_DIGITS=4, SCAN_DIV=6, DEAD_CYCLES=2): `fnd_com` follows 1111×2, 1110×4, 1111×2, 1101×4, … 0111. `frame_start` pulses every 24 cycles.
- Double buffer: load 16'h1234 mid-frame → `pending`=1 and the display is unchanged until the boundary. The next frame shows f9,a4,b0,99 on digits 3..0, and `pending`=0.
- Load collision: load A at a boundary with B already pending → the next frame shows B, `pending` stays 1, and the following frame shows A.
- Leading zeros: data 16'h0042, `blank_lz`=1 → digits 3,2 = 8'hff, digit 1 = 8'h99, digit 0 = 8'ha4. Data 16'h0000 → digit 0 = 8'hc0 and the others are blank.
- Dot and blink (BLINK_DIV=10): `dot_en`=4'b0100, `blink_en`=4'b0001 → digit 2 bit 7 = 0. Digit 0 alternates between pattern and 8'hff every 10 cycles. Assert `reset` mid-frame → outputs go to 1111/8'hff asynchronously.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants and the BCD-to-segment table for the FND scanner.
package fnd_pkg;

    // Active-low common-anode patterns with bit 7 = dp (off), bits 6:0 = g..a
    localparam logic [7:0] SEG_0   = 8'hc0;
    localparam logic [7:0] SEG_1   = 8'hf9;
    localparam logic [7:0] SEG_2   = 8'ha4;
    localparam logic [7:0] SEG_3   = 8'hb0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hf8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_OFF = 8'hff;

    localparam int SCAN_DIV_DEF    = 100_000;
    localparam int DEAD_CYCLES_DEF = 2;
    localparam int BLINK_DIV_DEF   = 50_000_000;

    // Non-decimal nibbles (A-F) render as a dark digit
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] nib);
        case (nib)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// One digit's segment pattern: BCD glyph, dp, leading-zero blank, blink blank.
module fnd_seg_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    input  logic       blank,
    input  logic       blink_off,
    output logic [7:0] seg
);

    logic [7:0] raw;

    // Blink blanking wins over everything, dp included
    always_comb begin
        raw = bcd_to_seg(nibble);
        seg = {~dot, raw[6:0]};
        if (blank)
            seg[6:0] = 7'h7f;
        if (blink_off)
            seg = SEG_OFF;
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = SCAN_DIV_DEF,
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int BLINK_DIV   = BLINK_DIV_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dot_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic                    pending,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   fnd_com,
    output logic [7:0]              fnd_data
);

    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  blink_on;
    logic [DW-1:0]         pend_data, sh_data;
    logic [NUM_DIGITS-1:0] pend_dot, sh_dot;
    logic [NUM_DIGITS-1:0] pend_blink, sh_blink;
    logic                  cnt_tc, frame_tc;

    logic [NUM_DIGITS-1:0][7:0] seg;

    assign cnt_tc   = (cnt == CW'(SCAN_DIV - 1));
    assign frame_tc = cnt_tc && (idx == IW'(NUM_DIGITS - 1));

    // Slot prescaler and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt_tc) begin
            cnt <= '0;
            idx <= frame_tc ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Free-running blink phase, starts in the visible half
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcnt     <= '0;
            blink_on <= 1'b1;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt     <= '0;
            blink_on <= ~blink_on;
        end else begin
            bcnt     <= bcnt + 1'b1;
        end
    end

    // Pending buffer takes every load; a load on the boundary cycle stays pending
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_data  <= '0;
            pend_dot   <= '0;
            pend_blink <= '0;
            pending    <= 1'b0;
        end else if (load) begin
            pend_data  <= digit_data;
            pend_dot   <= dot_en;
            pend_blink <= blink_en;
            pending    <= 1'b1;
        end else if (frame_tc) begin
            pending    <= 1'b0;
        end
    end

    // Shadow only moves on a frame boundary so a frame never mixes data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_data  <= '0;
            sh_dot   <= '0;
            sh_blink <= '0;
        end else if (frame_tc && pending) begin
            sh_data  <= pend_data;
            sh_dot   <= pend_dot;
            sh_blink <= pend_blink;
        end
    end

    // Per-digit decode; a digit is a leading zero when it and everything above it is 0
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        logic lz;
        assign lz = (i != 0) && (sh_data[DW-1:4*i] == '0);
        fnd_seg_decoder u_dec (
            .nibble    (sh_data[4*i +: 4]),
            .dot       (sh_dot[i]),
            .blank     (blank_lz && lz),
            .blink_off (sh_blink[i] && !blink_on),
            .seg       (seg[i])
        );
    end

    // Registered pin drive with dead time at the head of each slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fnd_com     <= '1;
            fnd_data    <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_tc;
            if (cnt < CW'(DEAD_CYCLES)) begin
                fnd_com  <= '1;
                fnd_data <= SEG_OFF;
            end else begin
                fnd_com  <= ~(NUM_DIGITS'(1) << idx);
                fnd_data <= seg[idx];
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized bench for fnd_scan_controller against a cycle-count based model.
module tb_fnd_scan_controller;

    localparam int ND = 4;
    localparam int SD = 6;
    localparam int DC = 2;
    localparam int BD = 10;
    localparam int FR = SD * ND;

    logic          clk, reset, load, blank_lz;
    logic [15:0]   digit_data;
    logic [3:0]    dot_en, blink_en;
    logic          pending, frame_start;
    logic [3:0]    fnd_com;
    logic [7:0]    fnd_data;

    int checks = 0;
    int fails  = 0;

    // model: n = edges since reset release; buffers as plain variables
    int          n;
    logic [15:0] m_pd, m_sd;
    logic [3:0]  m_pdot, m_sdot, m_pbl, m_sbl;
    bit          m_pv;
    logic [3:0]  e_com;
    logic [7:0]  e_data;
    bit          e_fs;

    fnd_scan_controller #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .DEAD_CYCLES(DC),
        .BLINK_DIV  (BD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .digit_data (digit_data),
        .dot_en     (dot_en),
        .blink_en   (blink_en),
        .blank_lz   (blank_lz),
        .pending    (pending),
        .frame_start(frame_start),
        .fnd_com    (fnd_com),
        .fnd_data   (fnd_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            0: return 8'hc0; 1: return 8'hf9; 2: return 8'ha4; 3: return 8'hb0;
            4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hf8;
            8: return 8'h80; 9: return 8'h90;
            default: return 8'hff;
        endcase
    endfunction

    function automatic logic [7:0] exp_digit(input int i, input bit bon);
        logic [7:0] t;
        if (m_sbl[i] && !bon) return 8'hff;
        t = glyph(m_sd[4*i +: 4]);
        if (blank_lz && i != 0 && (m_sd >> (4*i)) == 16'h0) t[6:0] = 7'h7f;
        t[7] = ~m_sdot[i];
        return t;
    endfunction

    task automatic model_reset();
        n = 0; m_pv = 0;
        m_pd = '0; m_sd = '0; m_pdot = '0; m_sdot = '0; m_pbl = '0; m_sbl = '0;
    endtask

    // One clock: predict from pre-edge state and inputs, advance model, compare at negedge
    task automatic tick();
        int c, d;
        bit bon, bnd;
        c   = n % SD;
        d   = (n / SD) % ND;
        bon = ((n / BD) % 2) == 0;
        bnd = (n % FR) == FR - 1;
        if (c < DC) begin
            e_com = 4'hf; e_data = 8'hff;
        end else begin
            e_com = ~(4'b0001 << d); e_data = exp_digit(d, bon);
        end
        e_fs = bnd;
        if (bnd && m_pv) begin
            m_sd = m_pd; m_sdot = m_pdot; m_sbl = m_pbl;
        end
        if (load) begin
            m_pd = digit_data; m_pdot = dot_en; m_pbl = blink_en; m_pv = 1;
        end else if (bnd) begin
            m_pv = 0;
        end
        n++;
        @(posedge clk);
        @(negedge clk);
        chk("fnd_com", 32'(fnd_com), 32'(e_com));
        chk("fnd_data", 32'(fnd_data), 32'(e_data));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("pending", 32'(pending), 32'(m_pv));
    endtask

    task automatic run(input int k);
        repeat (k) tick();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] bl);
        digit_data = d; dot_en = dt; blink_en = bl; load = 1;
        tick();
        load = 0;
    endtask

    task automatic reset_check(input string tag);
        #1;
        chk({tag, "_com"}, 32'(fnd_com), 32'hf);
        chk({tag, "_data"}, 32'(fnd_data), 32'hff);
        chk({tag, "_pend"}, 32'(pending), 32'h0);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    endtask

    initial begin
        logic [15:0] rd;
        reset = 0; load = 0; blank_lz = 0;
        digit_data = '0; dot_en = '0; blink_en = '0;
        model_reset();
        #12;
        reset_check("rst");
        @(negedge clk);
        reset = 1;

        // scan order and digit 0 = c0 with zeroed shadow
        run(2 * FR);
        // double buffer: mid-frame load
        while (n % FR != 7) tick();
        do_load(16'h1234, 4'h0, 4'h0);
        run(2 * FR);
        // leading zeros
        blank_lz = 1;
        do_load(16'h0042, 4'h0, 4'h0);
        run(2 * FR);
        do_load(16'h0000, 4'h0, 4'h0);
        run(2 * FR);
        // load collision on boundary with B pending
        while (n % FR != 5) tick();
        do_load(16'h5678, 4'h0, 4'h0);
        while (n % FR != FR - 1) tick();
        do_load(16'h9abc, 4'h3, 4'h0);
        run(3 * FR);
        // dot and blink
        blank_lz = 0;
        do_load(16'h4321, 4'b0100, 4'b0001);
        run(4 * FR);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                rd = 16'($urandom) >> (4 * $urandom_range(0, 4));
                do_load(rd, 4'($urandom), 4'($urandom));
            end else begin
                if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
                tick();
            end
        end

        // asynchronous reset mid-frame, pending data discarded
        do_load(16'h8888, 4'hf, 4'h0);
        run(3);
        #2;
        reset = 0;
        reset_check("mid_rst");
        @(negedge clk);
        reset_check("held_rst");
        reset = 1;
        model_reset();
        run(3 * FR);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                do_load(16'($urandom), 4'($urandom), 4'($urandom));
            else
                tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
